// File: rtl/reg_scoreboard_bank_if.sv
// Bundle of the register/scoreboard bank's operand-read, writeback, issue and debug signals.
// The master side drives requests; the slave side is the bank itself.
interface reg_scoreboard_bank_if #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned RAW    = 2
);
  localparam int unsigned NREG = 2 ** RAW;

  logic              en_in;
  logic [RAW-1:0]    rs1_addr;
  logic [RAW-1:0]    rs2_addr;
  logic              rs1_used;
  logic              rs2_used;
  logic [DWIDTH-1:0] rs1_data;
  logic [DWIDTH-1:0] rs2_data;
  logic              wr_en;
  logic [RAW-1:0]    wr_addr;
  logic [DWIDTH-1:0] wr_data;
  logic              iss_en;
  logic [RAW-1:0]    iss_rd;
  logic              stall;
  logic [NREG-1:0]   pend_vec;
  logic [RAW-1:0]    dbg_addr;
  logic [DWIDTH-1:0] dbg_data;

  modport master (
    output en_in, rs1_addr, rs2_addr, rs1_used, rs2_used, wr_en, wr_addr, wr_data,
           iss_en, iss_rd, dbg_addr,
    input  rs1_data, rs2_data, stall, pend_vec, dbg_data
  );

  modport slave (
    input  en_in, rs1_addr, rs2_addr, rs1_used, rs2_used, wr_en, wr_addr, wr_data,
           iss_en, iss_rd, dbg_addr,
    output rs1_data, rs2_data, stall, pend_vec, dbg_data
  );
endinterface

// File: rtl/reg_scoreboard_bank.sv
// Register bank with write-through bypass and a pending-write scoreboard for issue stalls.
// Define REG_ZERO_EN to make register 0 a hardwired zero that never goes pending.
module reg_scoreboard_bank #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned RAW    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  reg_scoreboard_bank_if.slave bus
);
  localparam int unsigned NREG = 2 ** RAW;

  logic [DWIDTH-1:0] regs_q [NREG];
  logic [NREG-1:0]   pend_q, pend_d;
  logic              wb, wb_eff, set_ok;
  logic              byp1, byp2, byp_rd;
  logic              hazard_1, hazard_2, waw, issue;

  assign wb = bus.wr_en & bus.en_in;

`ifdef REG_ZERO_EN
  // Writes to x0 are dropped so it stays zero; with no bypass it also reads zero.
  assign wb_eff = wb & (bus.wr_addr != '0);
  assign set_ok = (bus.iss_rd != '0);
`else
  assign wb_eff = wb;
  assign set_ok = 1'b1;
`endif

  assign byp1   = wb_eff & (bus.wr_addr == bus.rs1_addr);
  assign byp2   = wb_eff & (bus.wr_addr == bus.rs2_addr);
  assign byp_rd = wb_eff & (bus.wr_addr == bus.iss_rd);

  assign bus.rs1_data = byp1 ? bus.wr_data : regs_q[bus.rs1_addr];
  assign bus.rs2_data = byp2 ? bus.wr_data : regs_q[bus.rs2_addr];
  assign bus.dbg_data = regs_q[bus.dbg_addr];

  // A same-cycle writeback to the pending register resolves the hazard.
  assign hazard_1  = bus.rs1_used & pend_q[bus.rs1_addr] & ~byp1;
  assign hazard_2  = bus.rs2_used & pend_q[bus.rs2_addr] & ~byp2;
  assign waw       = pend_q[bus.iss_rd] & ~byp_rd;
  assign bus.stall = ~bus.en_in | (bus.iss_en & (hazard_1 | hazard_2 | waw));
  assign issue     = bus.iss_en & bus.en_in & ~bus.stall;

  assign bus.pend_vec = pend_q;

  // Set is applied after clear so a same-register issue wins over the writeback.
  always_comb begin
    pend_d = pend_q;
    if (wb_eff) begin
      pend_d[bus.wr_addr] = 1'b0;
    end
    if (issue && set_ok) begin
      pend_d[bus.iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
    end else if (bus.en_in) begin
      pend_q <= pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_eff) begin
      regs_q[bus.wr_addr] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_reg_scoreboard_bank.sv
// Scoreboard bench for reg_scoreboard_bank: stimulus queues expectations, a negedge monitor checks.
module tb_reg_scoreboard_bank;
  localparam int unsigned DWIDTH = 16;
  localparam int unsigned RAW    = 2;
`ifdef REG_ZERO_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  typedef enum int {SelStall, SelPend, SelRs1, SelRs2, SelDbg, SelQueue} sel_e;
  typedef struct {
    string       name;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   drain_check = 1'b0;

  reg_scoreboard_bank_if #(.DWIDTH(DWIDTH), .RAW(RAW)) bus ();

  reg_scoreboard_bank #(.DWIDTH(DWIDTH), .RAW(RAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  // Monitor: combinational outputs are settled mid-cycle, so compare at the falling edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sel)
        SelStall: act = {31'd0, bus.stall};
        SelPend:  act = {28'd0, bus.pend_vec};
        SelRs1:   act = {16'd0, bus.rs1_data};
        SelRs2:   act = {16'd0, bus.rs2_data};
        SelDbg:   act = {16'd0, bus.dbg_data};
        default:  act = 32'hDEAD_BEEF;
      endcase
      n_checks++;
      if (act !== e.exp) begin
        n_errors++;
        $display("FAIL %s: got %0h want %0h", e.name, act, e.exp);
      end
    end
    if (drain_check) begin
      n_checks++;
      if (q.size() != 0) begin
        n_errors++;
        $display("FAIL queue_drain: got %0d want 0", q.size());
      end
    end
  end

  task automatic expect_val(input string name, input sel_e sel, input logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.exp  = v;
    q.push_back(e);
  endtask

  task automatic idle();
    bus.en_in    = 1'b1;
    bus.rs1_addr = '0;
    bus.rs2_addr = '0;
    bus.rs1_used = 1'b0;
    bus.rs2_used = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.iss_en   = 1'b0;
    bus.iss_rd   = '0;
    bus.dbg_addr = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic write(input logic [RAW-1:0] a, input logic [DWIDTH-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
  endtask

  task automatic issue(input logic [RAW-1:0] rd);
    bus.iss_en = 1'b1;
    bus.iss_rd = rd;
  endtask

  initial begin
    idle();
    bus.dbg_addr = 2'd2;
    bus.rs1_addr = 2'd1;
    bus.rs2_addr = 2'd3;
    expect_val("rst_stall", SelStall, 0);
    expect_val("rst_pend", SelPend, 0);
    expect_val("rst_rs1", SelRs1, 0);
    expect_val("rst_rs2", SelRs2, 0);
    expect_val("rst_dbg", SelDbg, 0);
    step();
    rst_n = 1'b1;

    // Write-through bypass; debug port has no bypass.
    step();
    write(2'd1, 16'h0003);
    bus.rs1_addr = 2'd1;
    bus.dbg_addr = 2'd1;
    expect_val("byp_rs1", SelRs1, 16'h0003);
    expect_val("byp_dbg_old", SelDbg, 0);
    step();
    bus.dbg_addr = 2'd1;
    bus.rs2_addr = 2'd1;
    expect_val("dbg_x1", SelDbg, 16'h0003);
    expect_val("rs2_x1", SelRs2, 16'h0003);

    // RAW hazard on x2 until its writeback.
    step();
    issue(2'd2);
    expect_val("iss2_stall", SelStall, 0);
    expect_val("iss2_pend_pre", SelPend, 0);
    step();
    issue(2'd3);
    bus.rs1_used = 1'b1;
    bus.rs1_addr = 2'd2;
    expect_val("raw_pend", SelPend, 4'b0100);
    expect_val("raw_stall", SelStall, 1);
    step();
    issue(2'd3);
    bus.rs1_used = 1'b1;
    bus.rs1_addr = 2'd2;
    expect_val("raw_stall_hold", SelStall, 1);
    expect_val("raw_pend_hold", SelPend, 4'b0100);
    step();
    issue(2'd3);
    bus.rs1_used = 1'b1;
    bus.rs1_addr = 2'd2;
    write(2'd2, 16'h0006);
    expect_val("raw_wb_stall", SelStall, 0);
    expect_val("raw_wb_rs1", SelRs1, 16'h0006);
    step();
    bus.dbg_addr = 2'd2;
    expect_val("after_raw_pend", SelPend, 4'b1000);
    expect_val("after_raw_dbg", SelDbg, 16'h0006);

    // WAW stall, then issue+writeback to the same pending register.
    step();
    issue(2'd3);
    expect_val("waw_stall", SelStall, 1);
    step();
    issue(2'd3);
    write(2'd3, 16'h0009);
    expect_val("set_prio_stall", SelStall, 0);
    step();
    bus.dbg_addr = 2'd3;
    expect_val("set_prio_pend", SelPend, 4'b1000);
    expect_val("set_prio_dbg", SelDbg, 16'h0009);

    // rs2 hazard stalls; an unused operand does not.
    step();
    issue(2'd0);
    bus.rs2_used = 1'b1;
    bus.rs2_addr = 2'd3;
    expect_val("rs2_hazard", SelStall, 1);
    step();
    issue(2'd1);
    bus.rs1_addr = 2'd3;
    expect_val("unused_no_stall", SelStall, 0);
    step();
    expect_val("pend_1010", SelPend, 4'b1010);

    // Disabled: everything frozen, stall forced high.
    step();
    bus.en_in = 1'b0;
    write(2'd1, 16'hAAAA);
    issue(2'd2);
    bus.rs1_addr = 2'd1;
    expect_val("dis_stall", SelStall, 1);
    expect_val("dis_rs1_nobyp", SelRs1, 16'h0003);
    step();
    bus.dbg_addr = 2'd1;
    expect_val("dis_dbg", SelDbg, 16'h0003);
    expect_val("dis_pend", SelPend, 4'b1010);

    // Writeback to a non-pending register leaves pend alone.
    step();
    write(2'd2, 16'h0077);
    step();
    bus.dbg_addr = 2'd2;
    expect_val("nonpend_dbg", SelDbg, 16'h0077);
    expect_val("nonpend_pend", SelPend, 4'b1010);

    // Clear x3 and set x2 in one cycle to reach 0110.
    step();
    write(2'd3, 16'h0005);
    issue(2'd2);
    expect_val("mix_stall", SelStall, 0);
    step();
    expect_val("pend_0110", SelPend, 4'b0110);

    // Asynchronous reset between edges.
    step();
    rst_n = 1'b0;
    bus.dbg_addr = 2'd1;
    bus.rs1_addr = 2'd2;
    bus.rs2_addr = 2'd3;
    expect_val("arst_pend", SelPend, 0);
    expect_val("arst_dbg", SelDbg, 0);
    expect_val("arst_rs1", SelRs1, 0);
    expect_val("arst_rs2", SelRs2, 0);
    step();
    rst_n = 1'b1;

    // Post-reset writeback to a formerly pending register only writes data.
    step();
    write(2'd1, 16'h1234);
    bus.rs1_addr = 2'd1;
    expect_val("post_rst_byp", SelRs1, 16'h1234);
    step();
    bus.dbg_addr = 2'd1;
    expect_val("post_rst_pend", SelPend, 0);
    expect_val("post_rst_dbg", SelDbg, 16'h1234);

    // Register 0 behaviour depends on build configuration.
    step();
    write(2'd0, 16'hFFFF);
    issue(2'd0);
    bus.rs1_addr = 2'd0;
    expect_val("x0_stall", SelStall, 0);
    expect_val("x0_rs1", SelRs1, ZERO_EN ? 32'h0 : 32'hFFFF);
    step();
    bus.dbg_addr = 2'd0;
    expect_val("x0_pend", SelPend, ZERO_EN ? 32'h0 : 32'h1);
    expect_val("x0_dbg", SelDbg, ZERO_EN ? 32'h0 : 32'hFFFF);

    step();
    drain_check = 1'b1;
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/reg_scoreboard_bank.md
REG_SCOREBOARD_BANK -- requirements
Module: reg_scoreboard_bank

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, meaning data width of each register.
REQ-002 SHALL have parameter RAW, default 2, meaning register address width; NREG = 2**RAW registers.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en_in  input  1  global enable; low freezes all state.
REQ-006 SHALL have ports rs1_addr, rs2_addr  input  RAW each  read-port register selects.
REQ-007 SHALL have ports rs1_used, rs2_used  input  1 each  the issuing instruction reads the port.
REQ-008 SHALL have ports rs1_data, rs2_data  output  DWIDTH each  read-port data.
REQ-009 SHALL have ports wr_en  input  1, wr_addr  input  RAW, wr_data  input  DWIDTH  writeback port.
REQ-010 SHALL have ports iss_en  input  1, iss_rd  input  RAW  instruction issue request and its destination.
REQ-011 SHALL have port stall  output  1  issue blocked this cycle.
REQ-012 SHALL have port pend_vec  output  NREG  per-register pending-write flags.
REQ-013 SHALL have ports dbg_addr  input  RAW, dbg_data  output  DWIDTH  side-effect-free debug read.

Function
REQ-014 SHALL define wb = wr_en & en_in; on a rising edge with wb high, reg[wr_addr] SHALL take wr_data.
REQ-015 SHALL drive rsN_data combinationally: wr_data if wb and wr_addr == rsN_addr, else reg[rsN_addr] (write-through bypass, zero latency).
REQ-016 SHALL drive dbg_data = reg[dbg_addr] with no bypass.
REQ-017 SHALL define hazard_N = rsN_used & pend[rsN_addr] & ~(wb & wr_addr == rsN_addr), for N = 1, 2.
REQ-018 SHALL define waw = pend[iss_rd] & ~(wb & wr_addr == iss_rd).
REQ-019 SHALL drive stall = ~en_in | (iss_en & (hazard_1 | hazard_2 | waw)), purely combinational.
REQ-020 SHALL define issue = iss_en & en_in & ~stall; on a rising edge, pend[iss_rd] SHALL be set when issue is high.
REQ-021 SHALL clear pend[wr_addr] on a rising edge when wb is high.
REQ-022 SHALL give set priority when issue and wb target the same register in the same cycle: pend stays 1 and the data is written.
REQ-023 SHALL accept a writeback to a non-pending register: data is written, pend is unchanged.
REQ-024 SHALL change no register or pend bit on a rising edge while en_in is low; inputs are ignored.
REQ-025 SHALL drive pend_vec = pend directly from the flops.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously clear every register and every pend bit to 0.
REQ-027 SHALL, after reset and with en_in high and no pending bits, drive stall = 0, pend_vec = 0, rs1_data = rs2_data = dbg_data = 0.
REQ-028 SHALL, on reset asserted mid-operation, discard all outstanding pending writes; a later writeback to that register SHALL only write data.

Configuration
REQ-029 SHALL use macro REG_ZERO_EN: when defined, register 0 reads as 0 on every port, writes to it are dropped, its pend bit never sets, and it never causes a hazard or WAW stall.
REQ-030 SHALL, when REG_ZERO_EN is undefined, treat register 0 as an ordinary writable register (default build).

Verification
REQ-031 SHALL cover: reset; wr_en=1, wr_addr=1, wr_data=16'h0003 -> same-cycle rs1_addr=1 reads 0003; next cycle dbg_addr=1 reads 0003.
REQ-032 SHALL cover: issue rd=2 -> pend_vec=4'b0100; next cycle iss_en with rs1_used, rs1_addr=2 -> stall=1 until writeback of 16'h0006 to x2, same-cycle stall=0 and rs1_data=0006.
REQ-033 SHALL cover: pend[3]=1, issue rd=3 with writeback to x3 in the same cycle -> stall=0, x3 written, pend[3] remains 1.
REQ-034 SHALL cover: en_in=0 with wr_en=1 to x1 and iss_en=1 -> stall=1, x1 and pend_vec unchanged after the edge.
REQ-035 SHALL cover: pend_vec=4'b0110, rst_n pulsed low between edges -> pend_vec=0 and all registers 0 immediately.
REQ-036 SHALL cover: with REG_ZERO_EN, write 16'hFFFF to x0 and issue rd=0 -> rs1_data on x0 = 0, pend_vec[0]=0, stall=0.
